// File: rtl/morse_tx_keyer.sv
// Morse keyer: accepts ASCII characters over valid/ready and keys out dits, dashes and gaps.
// Optional sidetone square wave on tone_out when MORSE_TX_SIDETONE_EN is defined.
module morse_tx_keyer #(
  parameter int unsigned UNIT_CYCLES = 50000,
  parameter int unsigned TONE_DIV    = 25000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic       busy,
  output logic       err,
  output logic       tone_out
);

  localparam int unsigned CYC_W = $clog2(UNIT_CYCLES + 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(UNIT_CYCLES - 1);

  if (UNIT_CYCLES < 1) begin : g_unit_chk
    $error("UNIT_CYCLES must be at least 1");
  end
  if (TONE_DIV < 1) begin : g_tone_chk
    $error("TONE_DIV must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    ELEM_GAP,
    CHAR_GAP,
    WORD_GAP
  } state_t;

  // {len[2:0], pat[4:0]}; len == 0 marks an unsupported code. 1 = dash, MSB-first from pat[len-1].
  function automatic logic [7:0] morse_rom(input logic [7:0] c);
    logic [7:0] r;
    r = 8'h00;
    case (c)
      8'h41: r = {3'd2, 5'b00001};  // A
      8'h42: r = {3'd4, 5'b01000};
      8'h43: r = {3'd4, 5'b01010};
      8'h44: r = {3'd3, 5'b00100};
      8'h45: r = {3'd1, 5'b00000};
      8'h46: r = {3'd4, 5'b00010};
      8'h47: r = {3'd3, 5'b00110};
      8'h48: r = {3'd4, 5'b00000};
      8'h49: r = {3'd2, 5'b00000};
      8'h4A: r = {3'd4, 5'b00111};
      8'h4B: r = {3'd3, 5'b00101};
      8'h4C: r = {3'd4, 5'b00100};
      8'h4D: r = {3'd2, 5'b00011};
      8'h4E: r = {3'd2, 5'b00010};
      8'h4F: r = {3'd3, 5'b00111};
      8'h50: r = {3'd4, 5'b00110};
      8'h51: r = {3'd4, 5'b01101};
      8'h52: r = {3'd3, 5'b00010};
      8'h53: r = {3'd3, 5'b00000};
      8'h54: r = {3'd1, 5'b00001};
      8'h55: r = {3'd3, 5'b00001};
      8'h56: r = {3'd4, 5'b00001};
      8'h57: r = {3'd3, 5'b00011};
      8'h58: r = {3'd4, 5'b01001};
      8'h59: r = {3'd4, 5'b01011};
      8'h5A: r = {3'd4, 5'b01100};
      8'h30: r = {3'd5, 5'b11111};  // 0
      8'h31: r = {3'd5, 5'b01111};
      8'h32: r = {3'd5, 5'b00111};
      8'h33: r = {3'd5, 5'b00011};
      8'h34: r = {3'd5, 5'b00001};
      8'h35: r = {3'd5, 5'b00000};
      8'h36: r = {3'd5, 5'b10000};
      8'h37: r = {3'd5, 5'b11000};
      8'h38: r = {3'd5, 5'b11100};
      8'h39: r = {3'd5, 5'b11110};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  state_t           state;
  logic [CYC_W-1:0] cyc_cnt;
  logic [2:0]       unit_cnt;
  logic [2:0]       unit_target;
  logic [2:0]       elem_cnt;
  logic [4:0]       shreg;

  logic [7:0] up_char;
  logic [7:0] enc;
  logic [2:0] enc_len;
  logic [4:0] enc_aligned;
  logic       unit_tick;
  logic       unit_done;

  // Fold lower case, then left-align the pattern so the current element is always shreg[4].
  assign up_char     = (char_in >= 8'h61 && char_in <= 8'h7A) ? char_in - 8'h20 : char_in;
  assign enc         = morse_rom(up_char);
  assign enc_len     = enc[7:5];
  assign enc_aligned = 5'(enc[4:0] << (3'd5 - enc_len));
  assign unit_tick   = (cyc_cnt == CYC_LAST);
  assign unit_done   = unit_tick && (unit_cnt == unit_target - 3'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      key_out     <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      char_ready  <= 1'b1;
      cyc_cnt     <= '0;
      unit_cnt    <= '0;
      unit_target <= '0;
      elem_cnt    <= '0;
      shreg       <= '0;
    end else begin
      err <= 1'b0;
      if (state == IDLE) begin
        if (char_valid && char_ready) begin
          cyc_cnt  <= '0;
          unit_cnt <= '0;
          if (enc_len != 3'd0) begin
            state       <= MARK;
            shreg       <= enc_aligned;
            elem_cnt    <= enc_len;
            unit_target <= enc_aligned[4] ? 3'd3 : 3'd1;
            key_out     <= 1'b1;
            busy        <= 1'b1;
            char_ready  <= 1'b0;
          end else if (char_in == 8'h20) begin
            state       <= WORD_GAP;
            unit_target <= 3'd4;
            busy        <= 1'b1;
            char_ready  <= 1'b0;
          end else begin
            err <= 1'b1;
          end
        end
      end else begin
        cyc_cnt <= unit_tick ? '0 : cyc_cnt + 1'b1;
        if (unit_tick) unit_cnt <= unit_cnt + 3'd1;
        if (unit_done) begin
          unit_cnt <= '0;
          case (state)
            MARK: begin
              key_out <= 1'b0;
              if (elem_cnt == 3'd1) begin
                state       <= CHAR_GAP;
                unit_target <= 3'd3;
              end else begin
                state       <= ELEM_GAP;
                unit_target <= 3'd1;
                elem_cnt    <= elem_cnt - 3'd1;
                shreg       <= {shreg[3:0], 1'b0};
              end
            end
            ELEM_GAP: begin
              state       <= MARK;
              key_out     <= 1'b1;
              unit_target <= shreg[4] ? 3'd3 : 3'd1;
            end
            default: begin
              state      <= IDLE;
              busy       <= 1'b0;
              char_ready <= 1'b1;
            end
          endcase
        end
      end
    end
  end

`ifdef MORSE_TX_SIDETONE_EN
  localparam int unsigned TONE_W = $clog2(TONE_DIV + 1);

  logic [TONE_W-1:0] tone_cnt;
  logic              tone_q;

  // Divider idles in every gap, so each mark starts from a fresh phase.
  always_ff @(posedge clk) begin
    if (reset || !key_out) begin
      tone_cnt <= '0;
      tone_q   <= 1'b0;
    end else if (tone_cnt == TONE_W'(TONE_DIV - 1)) begin
      tone_cnt <= '0;
      tone_q   <= ~tone_q;
    end else begin
      tone_cnt <= tone_cnt + 1'b1;
    end
  end

  assign tone_out = tone_q & key_out;
`else
  assign tone_out = 1'b0;
`endif

endmodule

// File: tb/tb_morse_tx_keyer.sv
// Randomised scoreboard bench for morse_tx_keyer; expected waveforms come from a dot/dash string table.
module tb_morse_tx_keyer;

  localparam int unsigned U  = 4;
  localparam int unsigned TD = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic       key_out;
  logic       busy;
  logic       err;
  logic       tone_out;

  morse_tx_keyer #(.UNIT_CYCLES(U), .TONE_DIV(TD)) dut (
    .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .key_out(key_out), .busy(busy), .err(err), .tone_out(tone_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic key;
    logic busy;
    logic ready;
    logic err;
    logic tone;
  } obs_t;

  obs_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;

  string tbl[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                     "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                     "..-", "...-", ".--", "-..-", "-.--", "--..",
                     "-----", ".----", "..---", "...--", "....-",
                     ".....", "-....", "--...", "---..", "----."};

  function automatic int lookup(input logic [7:0] c);
    logic [7:0] u;
    u = c;
    if (u >= 8'h61 && u <= 8'h7A) u = u - 8'h20;
    if (u >= 8'h41 && u <= 8'h5A) return int'(u) - 32'h41;
    if (u >= 8'h30 && u <= 8'h39) return 26 + int'(u) - 32'h30;
    return -1;
  endfunction

  function automatic logic tone_at(input int j);
`ifdef MORSE_TX_SIDETONE_EN
    return ((j / TD) % 2) == 1;
`else
    return (j < 0);
`endif
  endfunction

  // Expected per-cycle observation for every cycle after the accepting edge.
  task automatic push_char(input logic [7:0] c);
    int    idx;
    string code;
    int    m;
    int    g;
    idx = lookup(c);
    if (idx >= 0) begin
      code = tbl[idx];
      for (int i = 0; i < code.len(); i++) begin
        m = (code[i] == "-") ? 3 : 1;
        g = (i == code.len() - 1) ? 3 : 1;
        for (int j = 0; j < m * U; j++) exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, tone_at(j)});
        for (int j = 0; j < g * U; j++) exp_q.push_back(obs_t'(5'b01000));
      end
      exp_q.push_back(obs_t'(5'b00100));
    end else if (c == 8'h20) begin
      for (int j = 0; j < 4 * U; j++) exp_q.push_back(obs_t'(5'b01000));
      exp_q.push_back(obs_t'(5'b00100));
    end else begin
      exp_q.push_back(obs_t'(5'b00110));
    end
  endtask

  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (mon_en) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : obs_t'(5'b00100);
      a = {key_out, busy, char_ready, err, tone_out};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL stream t=%0t key/busy/ready/err/tone got %b want %b", $time, a, e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", name, $time, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; holds char_valid until accepted, then records the expectation.
  task automatic send(input logic [7:0] c);
    int budget;
    char_in    = c;
    char_valid = 1'b1;
    budget     = 0;
    while (!char_ready && budget < 200) begin
      tick();
      budget++;
    end
    chk("accept_wait", 32'(char_ready), 32'd1);
    if (char_ready) begin
      tick();
      push_char(c);
    end
    char_valid = 1'b0;
    char_in    = 8'($urandom_range(0, 255));
  endtask

  function automatic logic [7:0] rand_char();
    logic [7:0] b;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: b = 8'(8'h41 + $urandom_range(0, 25));
      4, 5:       b = 8'(8'h61 + $urandom_range(0, 25));
      6, 7:       b = 8'(8'h30 + $urandom_range(0, 9));
      8:          b = 8'h20;
      default: begin
        b = 8'($urandom_range(0, 255));
        if (lookup(b) >= 0 || b == 8'h20) b = 8'h23;
      end
    endcase
    return b;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] directed[8];
    int         budget;
    directed = '{8'h45, 8'h41, 8'h20, 8'h23, 8'h61, 8'h54, 8'h30, 8'h7E};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_key", 32'(key_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(char_ready), 32'd1);
    chk("rst_tone", 32'(tone_out), 32'd0);
    mon_en = 1'b1;

    foreach (directed[i]) begin
      send(directed[i]);
      repeat ($urandom_range(0, 2)) tick();
    end
    for (int n = 0; n < 40; n++) begin
      send(rand_char());
      repeat ($urandom_range(0, 3)) tick();
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 300) begin
      tick();
      budget++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    tick();
    mon_en = 1'b0;

    // 'a' = dit, gap, dash; reset lands on the second cycle of the dash.
    char_in    = 8'h61;
    char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
    chk("a_first_mark", 32'(key_out), 32'd1);
    repeat (7) tick();
    chk("a_elem_gap", 32'(key_out), 32'd0);
    repeat (2) tick();
    chk("a_dash_2nd", 32'(key_out), 32'd1);
    chk("a_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_key", 32'(key_out), 32'd0);
    chk("abort_ready", 32'(char_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (U) tick();
    chk("abort_no_resume", 32'(key_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
